mandel_frame_scheduler: RTL and testbench
=========================================

Name: mandel_frame_scheduler

Overview:
- Sequences one Mandelbrot engine across a full pixel grid.
- On a frame request it latches the viewport configuration, then walks pixels in raster order (x fastest). For each pixel it generates c, pulses the engine's start, waits for the engine's completion pulse, and presents the result on a valid/ready pixel stream.
- Sits between the SPI config/decoder front end and the color converter / pixel output path.

Parameters:
- FIXED_POINT_WIDTH, 24, width of c values. Signed SII.FFF… format: 1 sign bit, 2 integer bits, rest fractional.
- H_RES, 640, pixels per row.
- V_RES, 480, rows per frame.
- ITER_WIDTH, 8, width of the iteration count.
- TIMEOUT_CYCLES, 1024, watchdog limit. Used only with the optional feature.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- frame_start  in  1  single-cycle request to render a frame
- cfg_real_origin  in  FIXED_POINT_WIDTH  c_real of pixel (0,0)
- cfg_imag_origin  in  FIXED_POINT_WIDTH  c_imag of pixel (0,0)
- cfg_step  in  FIXED_POINT_WIDTH  c increment per pixel, signed
- engine_start  out  1  one-cycle start pulse to the engine
- engine_c_real  out  FIXED_POINT_WIDTH  c_real for the current pixel
- engine_c_imag  out  FIXED_POINT_WIDTH  c_imag for the current pixel
- engine_done  in  1  engine result-valid pulse
- engine_is_mandelbrot  in  1  engine result
- engine_iterations  in  ITER_WIDTH  engine result
- pix_valid  out  1  pixel result available
- pix_ready  in  1  downstream accepts the pixel
- pix_x  out  clog2(H_RES)  pixel column
- pix_y  out  clog2(V_RES)  pixel row
- pix_iterations  out  ITER_WIDTH  captured iteration count
- pix_is_mandelbrot  out  1  captured result
- busy  out  1  high whenever the FSM is not in IDLE
- frame_done  out  1  one-cycle pulse after the last pixel handshake

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; x, y, c registers 0.
- FSM states: IDLE, ISSUE, WAIT, PRESENT, DONE.
- IDLE:
  - On frame_start, latch the three cfg inputs. Set x=0, y=0, c_real=cfg_real_origin, c_imag=cfg_imag_origin. Go to ISSUE next cycle.
  - frame_start is ignored in every state other than IDLE.
- ISSUE:
  - engine_start=1 for exactly this one cycle. engine_c_real/engine_c_imag are valid, and they stay stable until the next ISSUE.
  - Go to WAIT.
- WAIT:
  - On engine_done=1, capture engine_is_mandelbrot and engine_iterations into pix_*, then go to PRESENT.
  - engine_done seen during ISSUE is ignored; it counts as stale.
- PRESENT:
  - pix_valid=1. pix_x, pix_y and the result fields are held stable until pix_valid && pix_ready.
  - On that handshake:
    - If x<H_RES-1: x+=1, c_real+=step, go to ISSUE.
    - Else if y<V_RES-1: x=0, y+=1, c_real=latched origin, c_imag-=step (imaginary axis decreases down the screen), go to ISSUE.
    - Else go to DONE.
  - pix_valid deasserts the cycle after the handshake.
- DONE: frame_done=1 for one cycle, then go to IDLE. busy drops in IDLE.
- Arithmetic: c updates are two's-complement add/sub truncated to FIXED_POINT_WIDTH. Overflow wraps silently, with no saturation.
- Minimum per-pixel cost is 3 cycles: ISSUE, WAIT with immediate done, PRESENT with ready=1.
- Backpressure never drops or duplicates a pixel; the engine is not restarted while PRESENT is stalled.
- Reset asserted mid-frame aborts immediately. All outputs return to reset values, and no frame_done is emitted.
- Total pixel handshakes per frame = H_RES*V_RES, in raster order.

Optional Feature:
- Macro: MANDEL_SCHED_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT.
  - If it reaches TIMEOUT_CYCLES without engine_done, go to PRESENT with pix_iterations all ones and pix_is_mandelbrot=1. Also assert a sticky output timeout_flag.
  - timeout_flag is cleared on the next accepted frame_start or on reset.
  - The timeout_flag port exists only when the macro is defined.
- Not defined: no counter and no port; WAIT waits indefinitely.

Test Plan:
- Basic frame: H_RES=4, V_RES=2, FP=24, origin_real=0xC00000 (-2.0), origin_imag=0x200000 (1.0), step=0x100000 (0.5). Engine model returns done 2 cycles after start, ready=1 -> expect:
  - 8 handshakes in raster order;
  - pixel (1,0) has c_real=0xD00000, c_imag=0x200000;
  - pixel (0,1) has c_real=0xC00000, c_imag=0x100000;
  - one frame_done pulse, busy low afterwards.
- Backpressure: hold pix_ready=0 for 10 cycles at pixel (2,0) -> pix_* stable and no engine_start during the stall; the next engine_start comes the cycle after the handshake.
- Ignored request: pulse frame_start while busy, with different cfg -> current frame unaffected; no second frame starts.
- Reset mid-frame: drop nrst during WAIT of pixel (3,0) -> all outputs 0 asynchronously and no frame_done. A new frame_start then restarts at (0,0) with the new config.
- Stale done and wrap: engine_done asserted during ISSUE is ignored. origin_real=0x7FFFFF with step=1 -> pixel (1,0) c_real=0x800000 (wraps).
- Timeout (macro defined, TIMEOUT_CYCLES=16): engine never responds -> PRESENT after 16 WAIT cycles with iterations=0xFF, is_mandelbrot=1 and timeout_flag=1.

Source files
------------

// File: rtl/mandel_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : mandel_frame_scheduler_if
// Brief    : Engine command/result and pixel-stream bundle between the frame
//            scheduler (master) and the engine / pixel path (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface mandel_frame_scheduler_if #(
    parameter int FIXED_POINT_WIDTH = 24,
    parameter int ITER_WIDTH        = 8,
    parameter int H_RES             = 640,
    parameter int V_RES             = 480
);
    localparam int X_WIDTH = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_WIDTH = (V_RES > 1) ? $clog2(V_RES) : 1;

    // Engine command / result
    logic                         engine_start;
    logic [FIXED_POINT_WIDTH-1:0] engine_c_real;
    logic [FIXED_POINT_WIDTH-1:0] engine_c_imag;
    logic                         engine_done;
    logic                         engine_is_mandelbrot;
    logic [ITER_WIDTH-1:0]        engine_iterations;

    // Pixel result stream
    logic                         pix_valid;
    logic                         pix_ready;
    logic [X_WIDTH-1:0]           pix_x;
    logic [Y_WIDTH-1:0]           pix_y;
    logic [ITER_WIDTH-1:0]        pix_iterations;
    logic                         pix_is_mandelbrot;

    modport master (
        output engine_start, engine_c_real, engine_c_imag,
        input  engine_done, engine_is_mandelbrot, engine_iterations,
        output pix_valid, pix_x, pix_y, pix_iterations, pix_is_mandelbrot,
        input  pix_ready
    );

    modport slave (
        input  engine_start, engine_c_real, engine_c_imag,
        output engine_done, engine_is_mandelbrot, engine_iterations,
        input  pix_valid, pix_x, pix_y, pix_iterations, pix_is_mandelbrot,
        output pix_ready
    );
endinterface
`default_nettype wire

// File: rtl/mandel_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mandel_frame_scheduler
// Brief    : Walks one Mandelbrot engine across an H_RES x V_RES grid in
//            raster order, issuing c per pixel and streaming the results.
//            Optional watchdog: define MANDEL_SCHED_TIMEOUT_EN to force a
//            pixel out after TIMEOUT_CYCLES and expose timeout_flag.
// Revision : 1.0 - initial release
// ============================================================================
module mandel_frame_scheduler #(
    parameter int FIXED_POINT_WIDTH = 24,
    parameter int H_RES             = 640,
    parameter int V_RES             = 480,
    parameter int ITER_WIDTH        = 8,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         frame_start,
    input  logic [FIXED_POINT_WIDTH-1:0] cfg_real_origin,
    input  logic [FIXED_POINT_WIDTH-1:0] cfg_imag_origin,
    input  logic [FIXED_POINT_WIDTH-1:0] cfg_step,
    output logic                         busy,
    output logic                         frame_done,
`ifdef MANDEL_SCHED_TIMEOUT_EN
    output logic                         timeout_flag,
`endif
    mandel_frame_scheduler_if.master     bus
);

    localparam int X_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [X_W-1:0] C_X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] C_Y_LAST = Y_W'(V_RES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nxt;

    logic [FIXED_POINT_WIDTH-1:0] r_real_origin;
    logic [FIXED_POINT_WIDTH-1:0] r_step;
    logic [FIXED_POINT_WIDTH-1:0] r_c_real;
    logic [FIXED_POINT_WIDTH-1:0] r_c_imag;
    logic [X_W-1:0]               r_x;
    logic [Y_W-1:0]               r_y;
    logic [ITER_WIDTH-1:0]        r_pix_iter;
    logic                         r_pix_mandel;

    logic w_accept_frame;
    logic w_capture;
    logic w_handshake;
    logic w_timeout;
    logic w_engine_start;
    logic w_pix_valid;
    logic w_busy;
    logic w_frame_done;
    logic w_x_last;
    logic w_y_last;

    assign w_x_last = (r_x == C_X_LAST);
    assign w_y_last = (r_y == C_Y_LAST);

`ifdef MANDEL_SCHED_TIMEOUT_EN
    localparam int C_WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_WDOG_W-1:0] C_WDOG_LAST = C_WDOG_W'(TIMEOUT_CYCLES - 1);

    logic [C_WDOG_W-1:0] r_wdog;
    logic                r_timeout_flag;

    // A result that never arrives is forced out once the watchdog expires.
    assign w_timeout    = (r_state == S_WAIT) && !bus.engine_done && (r_wdog == C_WDOG_LAST);
    assign timeout_flag = r_timeout_flag;

    // Watchdog restarts from zero for every issued pixel and counts WAIT cycles.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wdog <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wdog <= '0;
        end else if (r_state == S_WAIT) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // Sticky timeout indication, cleared when a new frame is accepted.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_timeout_flag <= 1'b0;
        end else if (w_accept_frame) begin
            r_timeout_flag <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_flag <= 1'b1;
        end
    end
`else
    logic w_unused_timeout_cfg;

    assign w_timeout            = 1'b0;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state strobes/outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_accept_frame = 1'b0;
        w_capture      = 1'b0;
        w_handshake    = 1'b0;
        w_engine_start = 1'b0;
        w_pix_valid    = 1'b0;
        w_frame_done   = 1'b0;
        w_busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_accept_frame = 1'b1;
                    w_state_nxt    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_engine_start = 1'b1;
                w_state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (bus.engine_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_PRESENT;
                end else if (w_timeout) begin
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                w_pix_valid = 1'b1;
                if (bus.pix_ready) begin
                    w_handshake = 1'b1;
                    w_state_nxt = (w_x_last && w_y_last) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                w_frame_done = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Viewport latch, raster position and c stepping, result capture.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_real_origin <= '0;
            r_step        <= '0;
            r_c_real      <= '0;
            r_c_imag      <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_pix_iter    <= '0;
            r_pix_mandel  <= 1'b0;
        end else begin
            if (w_accept_frame) begin
                r_real_origin <= cfg_real_origin;
                r_step        <= cfg_step;
                r_c_real      <= cfg_real_origin;
                r_c_imag      <= cfg_imag_origin;
                r_x           <= '0;
                r_y           <= '0;
            end
            if (w_capture) begin
                r_pix_iter   <= bus.engine_iterations;
                r_pix_mandel <= bus.engine_is_mandelbrot;
            end else if (w_timeout) begin
                r_pix_iter   <= '1;
                r_pix_mandel <= 1'b1;
            end
            // Imaginary axis decreases down the screen; adds wrap silently.
            if (w_handshake) begin
                if (!w_x_last) begin
                    r_x      <= r_x + 1'b1;
                    r_c_real <= r_c_real + r_step;
                end else if (!w_y_last) begin
                    r_x      <= '0;
                    r_y      <= r_y + 1'b1;
                    r_c_real <= r_real_origin;
                    r_c_imag <= r_c_imag - r_step;
                end
            end
        end
    end

    assign bus.engine_start      = w_engine_start;
    assign bus.engine_c_real     = r_c_real;
    assign bus.engine_c_imag     = r_c_imag;
    assign bus.pix_valid         = w_pix_valid;
    assign bus.pix_x             = r_x;
    assign bus.pix_y             = r_y;
    assign bus.pix_iterations    = r_pix_iter;
    assign bus.pix_is_mandelbrot = r_pix_mandel;
    assign busy                  = w_busy;
    assign frame_done            = w_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_mandel_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mandel_frame_scheduler
// Brief    : Directed, table-driven bench for mandel_frame_scheduler on a
//            4x2 grid with a 2-cycle engine model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mandel_frame_scheduler;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] c_re;
        logic [23:0] c_im;
        logic [7:0]  iter;
        logic        mandel;
        int          stall;
    } vec_t;

    logic        clk;
    logic        nrst;
    logic        frame_start;
    logic [23:0] cfg_real_origin;
    logic [23:0] cfg_imag_origin;
    logic [23:0] cfg_step;
    logic        busy;
    logic        frame_done;
`ifdef MANDEL_SCHED_TIMEOUT_EN
    logic        timeout_flag;
`endif

    mandel_frame_scheduler_if #(.FIXED_POINT_WIDTH(24), .ITER_WIDTH(8), .H_RES(4), .V_RES(2)) bus ();

    mandel_frame_scheduler #(
        .FIXED_POINT_WIDTH(24), .H_RES(4), .V_RES(2), .ITER_WIDTH(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .frame_start    (frame_start),
        .cfg_real_origin(cfg_real_origin),
        .cfg_imag_origin(cfg_imag_origin),
        .cfg_step       (cfg_step),
        .busy           (busy),
        .frame_done     (frame_done),
`ifdef MANDEL_SCHED_TIMEOUT_EN
        .timeout_flag   (timeout_flag),
`endif
        .bus            (bus)
    );

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[24];

    // Engine model / monitor state
    int          start_cnt = 0;
    int          hs_cnt    = 0;
    int          fd_cnt    = 0;
    int          pend      = 0;
    int          cur_idx   = 0;
    bit          eng_en    = 1'b1;
    bit          stale_mode = 1'b0;
    logic [23:0] re_log[64];
    logic [23:0] im_log[64];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish (actual running, required finished)");
        $fatal(1, "global timeout");
    end

    // Engine model: acts just after each rising edge; result 2 cycles after start.
    initial begin
        bus.engine_done          = 1'b0;
        bus.engine_is_mandelbrot = 1'b0;
        bus.engine_iterations    = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus.engine_done = 1'b0;
            if (!nrst) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus.engine_done          = 1'b1;
                        bus.engine_iterations    = 8'h10 + 8'(cur_idx);
                        bus.engine_is_mandelbrot = cur_idx[0];
                    end
                end
                if (bus.engine_start === 1'b1) begin
                    cur_idx = start_cnt;
                    if (start_cnt < 64) begin
                        re_log[start_cnt] = bus.engine_c_real;
                        im_log[start_cnt] = bus.engine_c_imag;
                    end
                    start_cnt++;
                    if (stale_mode) begin
                        bus.engine_done          = 1'b1;
                        bus.engine_iterations    = 8'hEE;
                        bus.engine_is_mandelbrot = 1'b0;
                    end
                    if (eng_en) pend = 2;
                end
            end
        end
    end

    // Handshake and frame_done pulse monitor (pre-edge values).
    initial begin
        forever begin
            @(posedge clk);
            if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) hs_cnt++;
            if (frame_done === 1'b1) fd_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.pix_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: pix_valid actual 0 required 1 within 40 cycles");
        end
    endtask

    task automatic set_vec(input int i, input int x, input int y, input logic [23:0] re,
                           input logic [23:0] im, input int stall);
        vecs[i].x      = x;
        vecs[i].y      = y;
        vecs[i].c_re   = re;
        vecs[i].c_im   = im;
        vecs[i].iter   = 8'h10 + 8'(i % 8);
        vecs[i].mandel = ((i % 2) == 1);
        vecs[i].stall  = stall;
    endtask

    task automatic start_frame(input logic [23:0] re, input logic [23:0] im, input logic [23:0] st);
        start_cnt = 0;
        hs_cnt    = 0;
        fd_cnt    = 0;
        @(negedge clk);
        cfg_real_origin = re;
        cfg_imag_origin = im;
        cfg_step        = st;
        frame_start     = 1'b1;
        pix_ready_set(1'b1);
        @(negedge clk);
        frame_start     = 1'b0;
        cfg_real_origin = 24'hABCDEF;
        cfg_imag_origin = 24'h135791;
        cfg_step        = 24'h02468A;
    endtask

    task automatic pix_ready_set(input logic v);
        bus.pix_ready = v;
    endtask

    task automatic run_frame(input int base, input logic [23:0] re, input logic [23:0] im,
                             input logic [23:0] st, input bit use_stall, input bit inject);
        bit ok;
        bit hold_ok;
        int sc0;
        start_frame(re, im, st);
        check("busy_after_start", busy, 1);
        for (int k = 0; k < 8; k++) begin
            wait_valid(ok);
            if (!ok) return;
            check($sformatf("pix_x[%0d]", base + k), bus.pix_x, vecs[base + k].x);
            check($sformatf("pix_y[%0d]", base + k), bus.pix_y, vecs[base + k].y);
            check($sformatf("iter[%0d]", base + k), bus.pix_iterations, vecs[base + k].iter);
            check($sformatf("mandel[%0d]", base + k), bus.pix_is_mandelbrot, vecs[base + k].mandel);
            check($sformatf("c_re[%0d]", base + k), re_log[k], vecs[base + k].c_re);
            check($sformatf("c_im[%0d]", base + k), im_log[k], vecs[base + k].c_im);
            if (use_stall && vecs[base + k].stall > 0) begin
                pix_ready_set(1'b0);
                sc0     = start_cnt;
                hold_ok = 1'b1;
                repeat (vecs[base + k].stall) begin
                    @(negedge clk);
                    if (bus.pix_valid !== 1'b1 || bus.pix_x != 2'(vecs[base + k].x) ||
                        bus.pix_y != 1'(vecs[base + k].y) ||
                        bus.pix_iterations !== vecs[base + k].iter ||
                        bus.engine_start !== 1'b0) hold_ok = 1'b0;
                end
                check("stall_hold", hold_ok, 1);
                check("stall_no_start", start_cnt, sc0);
                pix_ready_set(1'b1);
                @(negedge clk);
                check("start_after_hs", bus.engine_start, 1);
            end
            if (inject && k == 1) begin
                frame_start     = 1'b1;
                cfg_real_origin = 24'h100000;
                cfg_imag_origin = 24'hF00000;
                cfg_step        = 24'h040000;
                @(negedge clk);
                frame_start = 1'b0;
            end
        end
        repeat (6) @(negedge clk);
        check("frame_done_cnt", fd_cnt, 1);
        check("busy_after_frame", busy, 0);
        check("handshakes", hs_cnt, 8);
        check("engine_starts", start_cnt, 8);
    endtask

    initial begin
        bit ok;
        int cnt;
        // Config A: origin (-2.0, 1.0), step 0.5
        set_vec(0, 0, 0, 24'hC00000, 24'h200000, 0);
        set_vec(1, 1, 0, 24'hD00000, 24'h200000, 0);
        set_vec(2, 2, 0, 24'hE00000, 24'h200000, 10);
        set_vec(3, 3, 0, 24'hF00000, 24'h200000, 0);
        set_vec(4, 0, 1, 24'hC00000, 24'h100000, 0);
        set_vec(5, 1, 1, 24'hD00000, 24'h100000, 0);
        set_vec(6, 2, 1, 24'hE00000, 24'h100000, 0);
        set_vec(7, 3, 1, 24'hF00000, 24'h100000, 0);
        // Config C: wrap at the positive limit, step 1
        set_vec(8,  0, 0, 24'h7FFFFF, 24'h000000, 0);
        set_vec(9,  1, 0, 24'h800000, 24'h000000, 0);
        set_vec(10, 2, 0, 24'h800001, 24'h000000, 0);
        set_vec(11, 3, 0, 24'h800002, 24'h000000, 0);
        set_vec(12, 0, 1, 24'h7FFFFF, 24'hFFFFFF, 0);
        set_vec(13, 1, 1, 24'h800000, 24'hFFFFFF, 0);
        set_vec(14, 2, 1, 24'h800001, 24'hFFFFFF, 0);
        set_vec(15, 3, 1, 24'h800002, 24'hFFFFFF, 0);
        // Config B: origin (0.5, -0.5), step 0.125
        set_vec(16, 0, 0, 24'h100000, 24'hF00000, 0);
        set_vec(17, 1, 0, 24'h140000, 24'hF00000, 0);
        set_vec(18, 2, 0, 24'h180000, 24'hF00000, 0);
        set_vec(19, 3, 0, 24'h1C0000, 24'hF00000, 0);
        set_vec(20, 0, 1, 24'h100000, 24'hEC0000, 0);
        set_vec(21, 1, 1, 24'h140000, 24'hEC0000, 0);
        set_vec(22, 2, 1, 24'h180000, 24'hEC0000, 0);
        set_vec(23, 3, 1, 24'h1C0000, 24'hEC0000, 0);

        nrst            = 1'b0;
        frame_start     = 1'b0;
        cfg_real_origin = 24'h0;
        cfg_imag_origin = 24'h0;
        cfg_step        = 24'h0;
        bus.pix_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_pix_valid", bus.pix_valid, 0);
        check("rst_engine_start", bus.engine_start, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_c_real", bus.engine_c_real, 0);
        check("rst_pix_iter", bus.pix_iterations, 0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame, then backpressure frame with an ignored mid-frame request
        run_frame(0, 24'hC00000, 24'h200000, 24'h100000, 1'b0, 1'b0);
        run_frame(0, 24'hC00000, 24'h200000, 24'h100000, 1'b1, 1'b1);

        // Stale done during ISSUE plus two's-complement wrap
        stale_mode = 1'b1;
        run_frame(8, 24'h7FFFFF, 24'h000000, 24'h000001, 1'b0, 1'b0);
        stale_mode = 1'b0;

        // Reset during WAIT of pixel (3,0)
        start_frame(24'hC00000, 24'h200000, 24'h100000);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (start_cnt >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        check("rst_reach_p3", ok, 1);
        @(negedge clk);
        check("rst_wait_x", bus.pix_x, 3);
        #1 nrst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_pix_valid", bus.pix_valid, 0);
        check("arst_pix_x", bus.pix_x, 0);
        check("arst_c_real", bus.engine_c_real, 0);
        check("arst_c_imag", bus.engine_c_imag, 0);
        check("arst_engine_start", bus.engine_start, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        check("arst_no_frame_done", fd_cnt, 0);
        run_frame(16, 24'h100000, 24'hF00000, 24'h040000, 1'b0, 1'b0);

`ifdef MANDEL_SCHED_TIMEOUT_EN
        // Engine never answers the first pixel
        eng_en = 1'b0;
        start_frame(24'hC00000, 24'h200000, 24'h100000);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.engine_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("to_issue_seen", ok, 1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cnt++;
            if (bus.pix_valid === 1'b1) break;
        end
        check("to_latency", cnt, 17);
        check("to_iter", bus.pix_iterations, 8'hFF);
        check("to_mandel", bus.pix_is_mandelbrot, 1);
        check("to_flag", timeout_flag, 1);
        eng_en = 1'b1;
        for (int k = 1; k < 8; k++) begin
            wait_valid(ok);
            if (!ok) break;
        end
        repeat (6) @(negedge clk);
        check("to_flag_sticky", timeout_flag, 1);
        check("to_frame_done", fd_cnt, 1);
        start_frame(24'hC00000, 24'h200000, 24'h100000);
        check("to_flag_cleared", timeout_flag, 0);
        for (int k = 0; k < 8; k++) begin
            wait_valid(ok);
            if (!ok) break;
        end
        repeat (6) @(negedge clk);
        check("to_flag_stays_clear", timeout_flag, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
